meter_credit_ctrl: RTL and testbench

- Controller that sequences the parking-meter credit register (14-bit seconds count, 0..9999): applies add requests (10/180/200/550 s), load requests (15/185 s) and the once-per-second decrement.
- Arbitrates simultaneous requests and drives display blanking for the low-credit and expired states.
- Sits between the debounced button inputs and the BCD display path; it is the sole owner of the count.

---
 rtl/meter_credit_ctrl_pkg.sv | 27 ++
 rtl/meter_credit_ctrl_if.sv | 25 ++
 rtl/meter_credit_ctrl_sec_prescaler.sv | 46 ++++
 rtl/meter_credit_ctrl.sv | 98 +++++++++
 tb/tb_meter_credit_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/meter_credit_ctrl_pkg.sv
// Shared constants, state encoding and saturating-add helper for the
// parking-meter credit controller.
package meter_pkg;

    localparam int          COUNT_W   = 14;
    localparam logic [13:0] ADD10     = 14'd10;
    localparam logic [13:0] ADD180    = 14'd180;
    localparam logic [13:0] ADD200    = 14'd200;
    localparam logic [13:0] ADD550    = 14'd550;
    localparam logic [13:0] LOAD15    = 14'd15;
    localparam logic [13:0] LOAD185   = 14'd185;
    localparam logic [13:0] MAX_COUNT = 14'd9999;

    typedef enum logic [1:0] {
        EXPIRED = 2'd0,
        LOW     = 2'd1,
        NORMAL  = 2'd2
    } meter_state_e;

    // Add in 15 bits so the sum can never wrap, then clamp to the ceiling.
    function automatic logic [13:0] sat_add(input logic [13:0] base, input logic [14:0] amt);
        logic [14:0] sum;
        sum = {1'b0, base} + amt;
        return (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[13:0];
    endfunction

endpackage

// File: rtl/meter_credit_ctrl_if.sv
// Button requests in, credit/display status out.
interface meter_credit_ctrl_if;
    import meter_pkg::*;

    logic         add10;
    logic         add180;
    logic         add200;
    logic         add550;
    logic         rst15;
    logic         rst185;
    logic [13:0]  BCOUNT;
    logic         blank;
    meter_state_e state;

    modport master (
        output add10, add180, add200, add550, rst15, rst185,
        input  BCOUNT, blank, state
    );

    modport slave (
        input  add10, add180, add200, add550, rst15, rst185,
        output BCOUNT, blank, state
    );

endinterface

// File: rtl/meter_credit_ctrl_sec_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1, pulses tick on the wrap cycle,
// flags the first half of the second and keeps a per-second parity bit.
module sec_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic half_low,
    output logic sec_par
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         sec_par_q, sec_par_d;

    assign tick     = (cnt_q == W'(TICK_DIV - 1));
    assign half_low = (cnt_q < W'(TICK_DIV / 2));
    assign sec_par  = sec_par_q;

    // Next count: a clear (credit load) restarts the second without toggling parity.
    always_comb begin
        cnt_d     = cnt_q + W'(1);
        sec_par_d = sec_par_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d     = '0;
            sec_par_d = ~sec_par_q;
        end
    end

    // Prescaler registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            sec_par_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sec_par_q <= sec_par_d;
        end
    end

endmodule

// File: rtl/meter_credit_ctrl.sv
// Parking-meter credit controller: sole owner of the seconds count.
// Optional macro METER_ADD_SUM_EN: simultaneous add presses are summed
// instead of largest-wins.
//
//   state   | meaning
//   EXPIRED | count == 0, digits blink at 1 Hz, 50% duty
//   LOW     | 0 < count < LOW_THRESH, digits on 1 s / off 1 s
//   NORMAL  | count >= LOW_THRESH, digits steady on
module meter_credit_ctrl
    import meter_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int LOW_THRESH = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    meter_credit_ctrl_if.slave   bus
);

    logic [5:0]   btn, btn_prev_q, btn_prev_d, req;
    logic [13:0]  count_q, count_d, base;
    logic [14:0]  amt;
    logic         load;
    logic         tick, half_low, sec_par;
    meter_state_e state_s;
    logic         blank_s;

    // Bit order: rst185, rst15, add550, add200, add180, add10.
    assign btn        = {bus.rst185, bus.rst15, bus.add550, bus.add200, bus.add180, bus.add10};
    assign btn_prev_d = btn;
    assign req        = btn & ~btn_prev_q;

    sec_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .clear    (load),
        .tick     (tick),
        .half_low (half_low),
        .sec_par  (sec_par)
    );

    // Next credit: loads win outright, otherwise decrement-then-add with saturation.
    always_comb begin
        amt     = '0;
        load    = 1'b0;
        count_d = count_q;
`ifdef METER_ADD_SUM_EN
        if (req[0]) amt = amt + 15'(ADD10);
        if (req[1]) amt = amt + 15'(ADD180);
        if (req[2]) amt = amt + 15'(ADD200);
        if (req[3]) amt = amt + 15'(ADD550);
`else
        if (req[3])      amt = 15'(ADD550);
        else if (req[2]) amt = 15'(ADD200);
        else if (req[1]) amt = 15'(ADD180);
        else if (req[0]) amt = 15'(ADD10);
`endif
        base = (tick && count_q != 14'd0) ? count_q - 14'd1 : count_q;
        if (req[5]) begin
            count_d = LOAD185;
            load    = 1'b1;
        end else if (req[4]) begin
            count_d = LOAD15;
            load    = 1'b1;
        end else begin
            count_d = sat_add(base, amt);
        end
    end

    // Credit and button-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            btn_prev_q <= '0;
        end else begin
            count_q    <= count_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    // Display state and blanking decoded from the registered count.
    always_comb begin
        state_s = NORMAL;
        blank_s = 1'b0;
        if (count_q == 14'd0) begin
            state_s = EXPIRED;
            blank_s = half_low;
        end else if (count_q < 14'(LOW_THRESH)) begin
            state_s = LOW;
            blank_s = sec_par;
        end
    end

    assign bus.BCOUNT = count_q;
    assign bus.state  = state_s;
    assign bus.blank  = blank_s;

endmodule

// File: tb/tb_meter_credit_ctrl.sv
// Directed bench for meter_credit_ctrl with a 10-cycle second.
module tb_meter_credit_ctrl;
    import meter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ps    = 0;
    bit   sp    = 1'b0;

    meter_credit_ctrl_if bus ();

    meter_credit_ctrl #(.TICK_DIV(10), .LOW_THRESH(200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; tracks where the one-second prescaler should be.
    task automatic step(input bit clr);
        @(posedge clk);
        #1;
        if (reset) begin
            ps = 0;
            sp = 1'b0;
        end else if (clr) begin
            ps = 0;
        end else if (ps == 9) begin
            ps = 0;
            sp = ~sp;
        end else begin
            ps++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        bus.add10 = 0; bus.add180 = 0; bus.add200 = 0; bus.add550 = 0;
        bus.rst15 = 0; bus.rst185 = 0;

        // Reset and idle in EXPIRED
        reset = 1'b1;
        step(1'b0); step(1'b0);
        chk("reset_bcount", 32'(bus.BCOUNT), 32'd0);
        chk("reset_state",  32'(bus.state),  32'(EXPIRED));
        chk("reset_blank",  32'(bus.blank),  32'd1);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0);
            chk("expired_blink", 32'(bus.blank), 32'(ps < 5));
        end
        chk("idle_bcount", 32'(bus.BCOUNT), 32'd0);
        chk("idle_state",  32'(bus.state),  32'(EXPIRED));

        // Load 185, prescaler restarts
        bus.rst185 = 1; step(1'b1); bus.rst185 = 0;
        chk("load185",       32'(bus.BCOUNT), 32'd185);
        chk("load185_state", 32'(bus.state),  32'(LOW));
        chk("low_blank0",    32'(bus.blank),  32'(sp));
        idle(9);
        chk("load185_no_tick", 32'(bus.BCOUNT), 32'd185);
        idle(1);
        chk("first_dec", 32'(bus.BCOUNT), 32'd184);
        chk("low_blank1", 32'(bus.blank), 32'd1);

        // Drive to saturation, bleed down to 9990
        for (int i = 0; i < 20; i++) begin
            bus.add550 = 1; step(1'b0);
            bus.add550 = 0; step(1'b0);
        end
        chk("sat_9998", 32'(bus.BCOUNT), 32'd9998);
        idle(80);
        chk("at_9990", 32'(bus.BCOUNT), 32'd9990);
        bus.add550 = 1; step(1'b0);
        chk("add550_sat",   32'(bus.BCOUNT), 32'd9999);
        chk("normal_state", 32'(bus.state),  32'(NORMAL));
        chk("normal_blank", 32'(bus.blank),  32'd0);
        bus.add550 = 0; bus.add10 = 1; step(1'b0);
        chk("add10_sat", 32'(bus.BCOUNT), 32'd9999);
        idle(29);
        chk("add10_held_no_repeat", 32'(bus.BCOUNT), 32'd9996);
        bus.add10 = 0; step(1'b0);

        // Simultaneous adds from 100
        bus.rst185 = 1; step(1'b1); bus.rst185 = 0;
        idle(850);
        chk("at_100", 32'(bus.BCOUNT), 32'd100);
        bus.add10 = 1; bus.add550 = 1; step(1'b0);
`ifdef METER_ADD_SUM_EN
        chk("dual_add", 32'(bus.BCOUNT), 32'd660);
`else
        chk("dual_add", 32'(bus.BCOUNT), 32'd650);
`endif
        bus.add10 = 0; bus.add550 = 0; step(1'b0);

        // Load beats add and tick from 50
        bus.rst185 = 1; step(1'b1); bus.rst185 = 0;
        idle(1359);
        chk("at_50", 32'(bus.BCOUNT), 32'd50);
        bus.rst15 = 1; bus.add200 = 1; step(1'b1);
        chk("load15_wins", 32'(bus.BCOUNT), 32'd15);
        chk("load15_state", 32'(bus.state), 32'(LOW));
        bus.rst15 = 0; bus.add200 = 0;
        idle(9);
        chk("load15_presc_cleared", 32'(bus.BCOUNT), 32'd15);
        idle(1);
        chk("load15_dec", 32'(bus.BCOUNT), 32'd14);
        bus.rst15 = 1; bus.rst185 = 1; step(1'b1);
        chk("rst185_over_rst15", 32'(bus.BCOUNT), 32'd185);
        bus.rst15 = 0; bus.rst185 = 0;

        // Expiry at 1 and add with coincident tick at 200
        idle(1849);
        chk("at_1", 32'(bus.BCOUNT), 32'd1);
        chk("at_1_state", 32'(bus.state), 32'(LOW));
        idle(1);
        chk("expire", 32'(bus.BCOUNT), 32'd0);
        chk("expire_state", 32'(bus.state), 32'(EXPIRED));
        idle(20);
        chk("hold_zero", 32'(bus.BCOUNT), 32'd0);
        bus.add200 = 1; step(1'b0); bus.add200 = 0;
        chk("at_200", 32'(bus.BCOUNT), 32'd200);
        chk("at_200_state", 32'(bus.state), 32'(NORMAL));
        idle(8);
        bus.add200 = 1; step(1'b0); bus.add200 = 0;
        chk("add_with_tick", 32'(bus.BCOUNT), 32'd399);
        chk("add_with_tick_state", 32'(bus.state), 32'(NORMAL));
        chk("add_with_tick_blank", 32'(bus.blank), 32'd0);
        step(1'b0);

        // Reset mid-operation with a button held through release
        bus.add550 = 1; reset = 1'b1; step(1'b0);
        chk("mid_reset", 32'(bus.BCOUNT), 32'd0);
        chk("mid_reset_state", 32'(bus.state), 32'(EXPIRED));
        reset = 1'b0; step(1'b0);
        chk("held_through_reset", 32'(bus.BCOUNT), 32'd550);
        step(1'b0);
        chk("held_no_repeat", 32'(bus.BCOUNT), 32'd550);
        bus.add550 = 0; step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
